// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   Oversampling 8N1 UART receiver with a one-deep valid/ready output holding
//   register.
//
//   The serial line is synchronised with two flops. A free-running divider
//   produces one sample tick every DIV clocks. Each bit spans OVERSAMPLE ticks,
//   and the bit value is the majority of three samples taken around the
//   middle of the bit.
//
//   Ports
//     clk        sole clock, rising edge
//     reset      synchronous, active-high
//     enable     receive enable; low forces the receiver back to idle
//     in         asynchronous serial RX line, idle high
//     ready      consumer accepts out this cycle
//     out[7:0]   received byte
//     valid      out holds an unconsumed byte
//     error      held byte had a bad (low) stop bit
//     overrun    one or more frames were dropped while valid was high
//     dbg_state  current receiver FSM state, for observation only
//
//   Handshake: a byte is transferred on every rising clk edge where valid and
//   ready are both high. valid stays high and out/error stay stable until that
//   transfer. ready is ignored while valid is low. After a transfer, out keeps
//   its last value.
module uart_rx_oversampled #(
  parameter int CLOCK_RATE = 24000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in,
  input  logic       ready,
  output logic [7:0] out,
  output logic       valid,
  output logic       error,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int M       = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0]       CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]       SMP_A    = 4'(M - 1);
  localparam logic [3:0]       SMP_B    = 4'(M);
  localparam logic [3:0]       SMP_C    = 4'(M + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       smp_q, smp_d;
  logic [7:0]       out_q, out_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             overrun_q, overrun_d;

  logic rx_s;
  logic tick;
  logic maj;
  logic frame_done;
  logic stop_good;
  logic handshake;

  assign rx_s = sync_q[1];
  assign tick = (div_q == DIV_LAST);
  // The first two samples of a bit are stored; the third is the live value.
  assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign handshake = valid_q & ready;

  // Synchroniser and sample-tick divider.
  always_comb begin
    sync_d = {sync_q[0], in};
    div_d  = tick ? '0 : div_q + 1'b1;
  end

  // Receiver FSM: next state, bit counter, bit index, samples, shift register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    smp_d      = smp_q;
    frame_done = 1'b0;
    stop_good  = 1'b1;

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
      if (cnt_q == SMP_A) smp_d[0] = rx_s;
      if (cnt_q == SMP_B) smp_d[1] = rx_s;

      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!rx_s) begin
            // The detecting tick is count 0 of the start bit, so the next
            // tick is count 1.
            state_d = S_START;
            cnt_d   = 4'd1;
          end
        end
        S_START: begin
          if (cnt_q == SMP_C && maj) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
        S_DATA: begin
          if (cnt_q == SMP_C) shift_d = {maj, shift_q[7:1]};
          if (cnt_q == CNT_LAST) begin
            if (idx_q == 3'd7) state_d = S_STOP;
            else               idx_d   = idx_q + 3'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == SMP_C) begin
            frame_done = 1'b1;
            stop_good  = maj;
            state_d    = maj ? S_IDLE : S_BREAK;
            cnt_d      = '0;
          end
        end
        S_BREAK: begin
          cnt_d = '0;
          if (rx_s) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output holding register. A frame that completes in the same cycle as a
  // transfer replaces the transferred byte instead of being counted as lost.
  always_comb begin
    out_d     = out_q;
    valid_d   = valid_q;
    error_d   = error_q;
    overrun_d = overrun_q;

    if (handshake) begin
      valid_d   = 1'b0;
      error_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (frame_done) begin
      if (!valid_q || handshake) begin
        out_d     = shift_q;
        valid_d   = 1'b1;
        error_d   = ~stop_good;
        overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      div_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      smp_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      smp_q     <= smp_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign error     = error_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled
//   Directed bench for uart_rx_oversampled at 24 MHz / 115200 baud / x16,
//   which gives 13 clocks per sample tick and 208 clocks per bit.
//
//   The reference model only knows frame-level facts. It knows each byte the
//   driver sends and the cycle its start edge was driven. The stop decision
//   lands about 9 + 10/16 bit times later, plus synchroniser delay and
//   tick-phase uncertainty. Inside that completion window the outputs may
//   show either the old or the new register contents. Outside the window
//   they must match the model exactly on every cycle.
module tb_uart_rx_oversampled;

  localparam int DIV    = 13;
  localparam int OS     = 16;
  localparam int BIT    = DIV * OS;
  localparam int LAT_LO = 1988;
  localparam int LAT_HI = 2010;
  localparam int NONE   = 99;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       in;
  logic       ready;
  logic [7:0] out;
  logic       valid;
  logic       error;
  logic       overrun;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected frames: {stop_error, byte} and the start-edge cycle.
  logic [8:0] exp_q[$];
  int         exp_t[$];

  // Model of the output register, plus the state after the pending frame.
  logic       m_valid = 1'b0;
  logic [7:0] m_out   = 8'h00;
  logic       m_err   = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       p_valid;
  logic [7:0] p_out;
  logic       p_err;
  logic       p_ovr;
  bit         armed   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_oversampled #(
    .CLOCK_RATE(24000000),
    .BAUD_RATE (115200),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in       (in),
    .ready    (ready),
    .out      (out),
    .valid    (valid),
    .error    (error),
    .overrun  (overrun),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- compare
  initial begin
    bit ok;
    forever begin
      @(negedge clk);
      if (!armed && exp_t.size() > 0 && cyc >= exp_t[0] + LAT_LO) begin
        armed = 1'b1;
        if (m_valid) begin
          p_valid = 1'b1; p_out = m_out; p_err = m_err; p_ovr = 1'b1;
        end else begin
          p_valid = 1'b1; p_out = exp_q[0][7:0]; p_err = exp_q[0][8]; p_ovr = 1'b0;
        end
      end
      if (armed && cyc >= exp_t[0] + LAT_HI) begin
        m_valid = p_valid; m_out = p_out; m_err = p_err; m_ovr = p_ovr;
        void'(exp_q.pop_front());
        void'(exp_t.pop_front());
        armed = 1'b0;
      end

      total++;
      ok = ({valid, out, error, overrun} === {m_valid, m_out, m_err, m_ovr}) ||
           (armed && ({valid, out, error, overrun} === {p_valid, p_out, p_err, p_ovr}));
      if (!ok) begin
        bad++;
        $display("FAIL cycle_compare cyc=%0d got v=%b out=%h e=%b o=%b want v=%b out=%h e=%b o=%b",
                 cyc, valid, out, error, overrun, m_valid, m_out, m_err, m_ovr);
      end

      if (reset) begin
        m_valid = 1'b0; m_out = 8'h00; m_err = 1'b0; m_ovr = 1'b0;
        exp_q.delete();
        exp_t.delete();
        armed = 1'b0;
      end else if (ready && m_valid && !armed) begin
        m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_regs(input string name, input logic [7:0] o, input logic v,
                            input logic e, input logic ov);
    check({name, "_out"}, out, o);
    check({name, "_valid"}, {7'd0, valid}, {7'd0, v});
    check({name, "_error"}, {7'd0, error}, {7'd0, e});
    check({name, "_overrun"}, {7'd0, overrun}, {7'd0, ov});
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    hold(1);
    ready = 1'b0;
  endtask

  // Sends one 8N1 frame with bit period per. Bit slots are numbered 0..7 for
  // the data bits. A spike inverts 10 clocks at the centre of a data bit. An
  // abort drops enable from that data bit until the stop bit. A reset pulse
  // lasts 3 clocks at the start of that data bit.
  task automatic send_frame(input logic [7:0] b, input int per, input bit expect_byte,
                            input int spike_bit, input int abort_bit, input int rst_bit);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    if (expect_byte) begin
      exp_t.push_back(cyc);
      exp_q.push_back({1'b0, b});
    end
    for (int i = 0; i < 10; i++) begin
      if (abort_bit != NONE && i - 1 == abort_bit) enable = 1'b0;
      if (abort_bit != NONE && i == 9) enable = 1'b1;
      in = bits[i];
      if (spike_bit != NONE && i - 1 == spike_bit) begin
        hold(per / 2 - 5);
        in = ~bits[i];
        hold(10);
        in = bits[i];
        hold(per - per / 2 - 5);
      end else if (rst_bit != NONE && i - 1 == rst_bit) begin
        reset = 1'b1;
        hold(3);
        reset = 1'b0;
        hold(per - 3);
      end else begin
        hold(per);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    in     = 1'b1;
    ready  = 1'b0;
    hold(5);
    reset = 1'b0;
    hold(20);
    check_regs("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Single byte, then a one-cycle handshake.
    send_frame(8'h55, BIT, 1'b1, NONE, NONE, NONE);
    hold(100);
    check_regs("byte_55", 8'h55, 1'b1, 1'b0, 1'b0);
    pulse_ready();
    check_regs("byte_55_taken", 8'h55, 1'b0, 1'b0, 1'b0);

    // ready while nothing is held.
    pulse_ready();
    hold(5);
    check_regs("idle_ready", 8'h55, 1'b0, 1'b0, 1'b0);

    // Two back-to-back frames without a handshake.
    send_frame(8'hA3, BIT, 1'b1, NONE, NONE, NONE);
    send_frame(8'h3C, BIT, 1'b1, NONE, NONE, NONE);
    hold(100);
    check_regs("overrun", 8'hA3, 1'b1, 1'b0, 1'b1);
    pulse_ready();
    check_regs("overrun_taken", 8'hA3, 1'b0, 1'b0, 1'b0);
    hold(50);

    // Line held low for 12 bit times: break.
    exp_t.push_back(cyc);
    exp_q.push_back({1'b1, 8'h00});
    in = 1'b0;
    hold(12 * BIT);
    check_regs("break_low", 8'h00, 1'b1, 1'b1, 1'b0);
    in = 1'b1;
    hold(400);
    check_regs("break", 8'h00, 1'b1, 1'b1, 1'b0);
    pulse_ready();
    check_regs("break_taken", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h7E, BIT, 1'b1, NONE, NONE, NONE);
    hold(100);
    check_regs("after_break", 8'h7E, 1'b1, 1'b0, 1'b0);
    pulse_ready();

    // Short low glitch on an idle line.
    hold(100);
    in = 1'b0;
    hold(3 * DIV);
    in = 1'b1;
    hold(2500);
    check_regs("glitch", 8'h7E, 1'b0, 1'b0, 1'b0);

    // One-tick spike inside data bit 5 (a 1) of 0xF0.
    send_frame(8'hF0, BIT, 1'b1, 5, NONE, NONE);
    hold(100);
    check_regs("spike", 8'hF0, 1'b1, 1'b0, 1'b0);
    pulse_ready();

    // Enable dropped during bit 4 of 0x81, then a clean 0x81.
    hold(100);
    send_frame(8'h81, BIT, 1'b0, NONE, 4, NONE);
    hold(500);
    check_regs("abort", 8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, BIT, 1'b1, NONE, NONE, NONE);
    hold(100);
    check_regs("after_abort", 8'h81, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame while a byte is still held.
    send_frame(8'hFF, BIT, 1'b0, NONE, NONE, 3);
    hold(300);
    check_regs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Baud skew of +3% and -3%.
    send_frame(8'h5A, 214, 1'b1, NONE, NONE, NONE);
    hold(100);
    check_regs("slow_5a", 8'h5A, 1'b1, 1'b0, 1'b0);
    pulse_ready();
    hold(100);
    send_frame(8'hC3, 202, 1'b1, NONE, NONE, NONE);
    hold(100);
    check_regs("fast_c3", 8'hC3, 1'b1, 1'b0, 1'b0);
    pulse_ready();
    hold(20);
    check_regs("final", 8'hC3, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 24000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; legal range 8..16.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  receive enable.
REQ-007 SHALL have port in  input  1  asynchronous serial RX line, idle high.
REQ-008 SHALL have port ready  input  1  consumer accepts out this cycle.
REQ-009 SHALL have port out  output  8  received byte.
REQ-010 SHALL have port valid  output  1  out holds an unconsumed byte.
REQ-011 SHALL have port error  output  1  held byte had a bad stop bit.
REQ-012 SHALL have port overrun  output  1  one or more frames dropped while valid was high.

Function
REQ-013 SHALL pass in through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-014 SHALL generate a one-cycle sample tick every DIV = CLOCK_RATE/(BAUD_RATE*OVERSAMPLE) clocks (integer division, DIV>=1); the divider is free-running and resets to 0.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK; state changes and sampling occur only on tick cycles, except enable/reset forcing.
REQ-016 SHALL keep a per-bit tick counter 0..OVERSAMPLE-1; samples are taken at counts M-1, M, M+1 with M = OVERSAMPLE/2, and the bit value is the majority of the 3 samples.
REQ-017 IDLE: on a tick with rx_s==0 -> START, counter=0, with the start tick itself counted as count 0.
REQ-018 START: if the majority at count M+1 is 1 (false start) -> IDLE; otherwise, at count OVERSAMPLE-1 -> DATA with bit index 0.
REQ-019 DATA: 8 bits, LSB first, shifted into a shift register; after bit 7 completes at count OVERSAMPLE-1 -> STOP.
REQ-020 STOP: decide at count M+1; majority 1 = good frame -> IDLE; majority 0 = framing error -> BREAK.
REQ-021 BREAK: remain until a tick with rx_s==1, then -> IDLE; no start detection in BREAK.
REQ-022 SHALL complete a frame on the STOP decision tick; on the next clock, with valid==0: out=shift register, valid=1, error=(stop majority==0).
REQ-023 On frame completion with valid==1 and no handshake in that cycle: out and error unchanged, new byte discarded, overrun=1.
REQ-024 On frame completion in the same cycle as valid&&ready: the new byte loads (REQ-022) and overrun stays 0.
REQ-025 Handshake valid&&ready: valid, error, overrun cleared next cycle unless REQ-024 applies; out holds its last value.
REQ-026 ready while valid==0 SHALL have no effect.
REQ-027 enable==0: FSM forced to IDLE and counter to 0 next clock, partial frame abandoned without error; valid/out/error/overrun unaffected and handshake still operates.
REQ-028 Latency: valid rises 1 clock after the stop decision tick, i.e. about (9 + (M+2)/OVERSAMPLE) bit times after the start falling edge plus 2-3 synchronizer clocks.

Reset
REQ-029 On reset: state=IDLE, divider=0, bit counter=0, bit index=0, shift register=0, synchronizer flops=1, out=0x00, valid=0, error=0, overrun=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame and produce no valid pulse; reset has priority over enable and the handshake.

Verification
REQ-031 Frame 0x55 at 115200 baud with ready=0 -> valid=1, out=0x55, error=0, overrun=0; then ready=1 for 1 clock -> valid=0 next clock.
REQ-032 Frames 0xA3 then 0x3C with ready held 0 -> out=0xA3, valid=1, overrun=1 after the second stop bit; handshake clears all flags.
REQ-033 Line low for 12 bit times then high -> out=0x00, valid=1, error=1; no second frame until in returns high; a following 0x7E is received correctly after the handshake.
REQ-034 Glitch low of 3 bit-ticks on idle line -> false start, no valid; a single-tick spike inside a data bit of 0xF0 -> still out=0xF0 (majority vote).
REQ-035 enable=0 pulsed during bit 4 of 0x81 -> no valid for that frame; the next 0x81 is received correctly; reset mid-frame -> all outputs at reset values.
REQ-036 Baud skew of +/-3% on 0x5A and 0xC3, at CLOCK_RATE 24 MHz with DIV=13 -> both bytes received correctly with error=0.
